// File: rtl/s2p_pkg.sv
// Shared types and constants for the SPI serial-to-parallel receiver.
package s2p_pkg;

    // Receiver FSM states
    typedef enum logic [0:0] {
        S2P_IDLE,
        S2P_RECV
    } s2p_state_t;

    // Depth of the spi_clk / serial_in synchronisers
    localparam int unsigned S2P_SYNC_STAGES = 2;

    // Bits per SPI frame: data bits plus an optional trailing parity bit
    function automatic int unsigned s2p_frame_len(input int unsigned word_w,
                                                  input bit          parity_en);
        return parity_en ? word_w + 1 : word_w;
    endfunction

endpackage

// File: rtl/s2p_sync_edge.sv
// Synchronises spi_clk and serial_in into iclk and detects spi_clk edges.
// Both inputs see the same synchroniser depth so data stays aligned to rise.
module s2p_sync_edge
    import s2p_pkg::*;
(
    input  logic iclk,
    input  logic rst,
    input  logic spi_clk,
    input  logic serial_in,
    output logic data_s,
    output logic rise,
    output logic any_edge
);

    logic [S2P_SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [S2P_SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                       clk_prev_q, clk_prev_d;
    logic                       clk_s;

    assign clk_s = clk_sync_q[S2P_SYNC_STAGES-1];

    // Next-state: shift both synchronisers, remember last synchronised clock
    always_comb begin
        clk_sync_d = {clk_sync_q[S2P_SYNC_STAGES-2:0], spi_clk};
        dat_sync_d = {dat_sync_q[S2P_SYNC_STAGES-2:0], serial_in};
        clk_prev_d = clk_s;
    end

    // Synchroniser and edge-detect flops
    always_ff @(posedge iclk) begin
        if (rst) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign data_s   = dat_sync_q[S2P_SYNC_STAGES-1];
    assign rise     = clk_s & ~clk_prev_q;
    assign any_edge = clk_s ^ clk_prev_q;

endmodule

// File: rtl/spi_s2p_rx.sv
// SPI serial-to-parallel receiver, fully in the iclk domain.
// Oversamples spi_clk/serial_in, assembles WORD_W-bit words in either bit order,
// aborts partial frames after IDLE_CYCLES without a clock edge, and presents
// words on a valid/ready output register.
// Optional feature: define S2P_RX_PARITY_EN to append an even-parity bit to
// each frame and report mismatches on par_err.
module spi_s2p_rx
    import s2p_pkg::*;
#(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned MSB_FIRST   = 1
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              serial_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              frame_err,
    output logic              ovr_err,
    output logic              par_err
);

`ifdef S2P_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int unsigned FRAME_LEN = s2p_frame_len(WORD_W, PAR_EN);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned IDLE_W    = $clog2(IDLE_CYCLES + 1);

    logic data_s, rise, any_edge;

    s2p_sync_edge u_sync_edge (
        .iclk      (iclk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .serial_in (serial_in),
        .data_s    (data_s),
        .rise      (rise),
        .any_edge  (any_edge)
    );

    s2p_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [FRAME_LEN-1:0] shreg_shift;
    logic [WORD_W-1:0]    frame_word;
    logic                 frame_ok;
    logic                 complete;
    logic                 timeout;

    logic                 out_valid_q, out_valid_d;
    logic [WORD_W-1:0]    out_word_q, out_word_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ovr_err_q, ovr_err_d;
    logic                 consume;

    // Shift register with the current synchronised data bit inserted
    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_shift = {shreg_q[FRAME_LEN-2:0], data_s};
        end else begin
            shreg_shift = {data_s, shreg_q[FRAME_LEN-1:1]};
        end
    end

    // Data bits of the frame being completed; a parity bit, if any, sits at
    // the end opposite to the first data bit
    always_comb begin
        if (MSB_FIRST != 0) begin
            frame_word = shreg_shift[FRAME_LEN-1 -: WORD_W];
        end else begin
            frame_word = shreg_shift[WORD_W-1:0];
        end
    end

`ifdef S2P_RX_PARITY_EN
    // Even parity across data and parity bits
    assign frame_ok = ~(^shreg_shift);
`else
    assign frame_ok = 1'b1;
`endif

    // Receive FSM next-state: bit counting, idle timeout, shifting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        shreg_d  = shreg_q;
        complete = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            S2P_IDLE: begin
                idle_d = '0;
                if (rise) begin
                    shreg_d = shreg_shift;
                    cnt_d   = CNT_W'(1);
                    state_d = S2P_RECV;
                end
            end
            S2P_RECV: begin
                if (rise) begin
                    // An edge always beats a coincident timeout
                    shreg_d = shreg_shift;
                    idle_d  = '0;
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = S2P_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (any_edge) begin
                    idle_d = '0;
                end else if (idle_q >= IDLE_W'(IDLE_CYCLES - 1)) begin
                    // This cycle brings the idle count to IDLE_CYCLES
                    timeout = 1'b1;
                    idle_d  = '0;
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = S2P_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                state_d = S2P_IDLE;
            end
        endcase
    end

    // Receive FSM state, counters and shift register
    always_ff @(posedge iclk) begin
        if (rst) begin
            state_q <= S2P_IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            shreg_q <= shreg_d;
        end
    end

    assign consume = out_valid_q & out_ready;

    // Output slot next-state: load on completion when free or being consumed
    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        ovr_err_d   = 1'b0;
        frame_err_d = timeout;
        if (consume) begin
            out_valid_d = 1'b0;
        end
        // A parity-failed word touches neither the slot nor ovr_err
        if (complete && frame_ok) begin
            if (!out_valid_q || consume) begin
                out_word_d  = frame_word;
                out_valid_d = 1'b1;
            end else begin
                ovr_err_d = 1'b1;
            end
        end
    end

    // Output slot and error pulse registers
    always_ff @(posedge iclk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            frame_err_q <= frame_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign frame_err = frame_err_q;
    assign ovr_err   = ovr_err_q;

`ifdef S2P_RX_PARITY_EN
    logic par_err_q, par_err_d;

    assign par_err_d = complete & ~frame_ok;

    // Parity error pulse register
    always_ff @(posedge iclk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_s2p_rx.sv
// Directed bench for spi_s2p_rx: one MSB-first and one LSB-first instance share
// the same SPI lines; SPI bits are 8 iclk periods long (4 low, 4 high).
module tb_spi_s2p_rx;

`ifdef S2P_RX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       iclk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       serial_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_word;
    logic       frame_err;
    logic       ovr_err;
    logic       par_err;

    logic       l_valid;
    logic [7:0] l_word;
    logic       l_frame;
    logic       l_ovr;
    logic       l_par;

    spi_s2p_rx #(
        .WORD_W      (8),
        .IDLE_CYCLES (4),
        .MSB_FIRST   (1)
    ) dut (
        .iclk      (iclk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .serial_in (serial_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .frame_err (frame_err),
        .ovr_err   (ovr_err),
        .par_err   (par_err)
    );

    spi_s2p_rx #(
        .WORD_W      (8),
        .IDLE_CYCLES (4),
        .MSB_FIRST   (0)
    ) dut_lsb (
        .iclk      (iclk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .serial_in (serial_in),
        .out_ready (1'b1),
        .out_valid (l_valid),
        .out_word  (l_word),
        .frame_err (l_frame),
        .ovr_err   (l_ovr),
        .par_err   (l_par)
    );

    always #5 iclk = ~iclk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_acc = 0;
    int         n_frame = 0;
    int         n_ovr = 0;
    int         n_par = 0;
    int         l_acc = 0;
    logic [7:0] last_word = 8'h00;
    logic [7:0] l_last = 8'h00;

    // Event monitor: samples mid-cycle, after the stimulus has settled
    always @(negedge iclk) begin
        #2;
        if (out_valid && out_ready) begin
            n_acc++;
            last_word = out_word;
        end
        if (l_valid) begin
            l_acc++;
            l_last = l_word;
        end
        if (frame_err) n_frame++;
        if (ovr_err)   n_ovr++;
        if (par_err)   n_par++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic clr();
        n_acc   = 0;
        n_frame = 0;
        n_ovr   = 0;
        n_par   = 0;
        l_acc   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        tick(4);
        spi_clk = 1'b1;
        tick(4);
        spi_clk = 1'b0;
    endtask

    // Sends one frame MSB of w first; ready_on_last pulses out_ready for the
    // single iclk cycle in which the final rise is detected
    task automatic send_frame(input logic [7:0] w, input bit good_par, input bit ready_on_last);
        logic [FL-1:0] bits;
`ifdef S2P_RX_PARITY_EN
        bits = {w, good_par ? ^w : ~(^w)};
`else
        bits = w;
        if (!good_par) $display("note: parity not compiled in, flag ignored");
`endif
        for (int i = FL - 1; i > 0; i--) send_bit(bits[i]);
        if (!ready_on_last) begin
            send_bit(bits[0]);
        end else begin
            serial_in = bits[0];
            tick(4);
            spi_clk = 1'b1;
            tick(2);
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
            tick(1);
            spi_clk = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        spi_clk   = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_word",  32'(out_word),  32'h0);
        check("rst_frame", 32'(frame_err), 32'h0);
        check("rst_ovr",   32'(ovr_err),   32'h0);
        check("rst_par",   32'(par_err),   32'h0);

        // Basic receive of 0xA5; LSB-first instance sees 1,0,1,0,0,1,0,1 -> 0xA5
        clr();
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(8);
        check("basic_acc",   32'(n_acc),     32'd1);
        check("basic_word",  32'(last_word), 32'hA5);
        check("basic_frame", 32'(n_frame),   32'd0);
        check("basic_ovr",   32'(n_ovr),     32'd0);
        check("basic_par",   32'(n_par),     32'd0);
        check("lsb_acc",     32'(l_acc),     32'd1);
        check("lsb_word",    32'(l_last),    32'hA5);

        // Partial frame of 5 bits then idle: one frame_err, nothing emitted
        clr();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(10);
        check("to_frame", 32'(n_frame), 32'd1);
        check("to_acc",   32'(n_acc),   32'd0);
        clr();
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(8);
        check("after_to_acc",   32'(n_acc),     32'd1);
        check("after_to_word",  32'(last_word), 32'h3C);
        check("after_to_frame", 32'(n_frame),   32'd0);

        // Overrun: slot full with 0x11, 0x22 dropped
        out_ready = 1'b0;
        clr();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(8);
        check("ovr_valid", 32'(out_valid), 32'h1);
        check("ovr_word",  32'(out_word),  32'h11);
        check("ovr_count", 32'(n_ovr),     32'd1);
        check("ovr_acc",   32'(n_acc),     32'd0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        check("drain_valid", 32'(out_valid), 32'h0);

        // Completion and consume in the same cycle: 0x22 replaces 0x11
        clr();
        send_frame(8'h11, 1'b1, 1'b0);
        tick(2);
        send_frame(8'h22, 1'b1, 1'b1);
        tick(8);
        check("sim_valid", 32'(out_valid), 32'h1);
        check("sim_word",  32'(out_word),  32'h22);
        check("sim_ovr",   32'(n_ovr),     32'd0);
        check("sim_acc",   32'(n_acc),     32'd1);
        out_ready = 1'b1;
        tick(2);

        // Reset after 4 zero bits, then 0xFF must arrive unmixed
        clr();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(8);
        check("mid_rst_acc",  32'(n_acc),     32'd1);
        check("mid_rst_word", 32'(last_word), 32'hFF);

`ifdef S2P_RX_PARITY_EN
        // Good parity
        clr();
        send_frame(8'h07, 1'b1, 1'b0);
        tick(8);
        check("par_ok_acc",  32'(n_acc),     32'd1);
        check("par_ok_word", 32'(last_word), 32'h07);
        check("par_ok_err",  32'(n_par),     32'd0);
        // Bad parity: word dropped, one par_err
        clr();
        send_frame(8'h07, 1'b0, 1'b0);
        tick(8);
        check("par_bad_err",   32'(n_par),     32'd1);
        check("par_bad_acc",   32'(n_acc),     32'd0);
        check("par_bad_valid", 32'(out_valid), 32'h0);
        check("par_bad_ovr",   32'(n_ovr),     32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
